// File: rtl/rv32i_lsu_pkg.sv
// Shared types and encodings for the rv32i load/store sequencer.
// Funct3 codes, exception causes, FSM state and legality helpers.
package rv32i_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_ILLEGAL  = 2'b10;
    localparam logic [1:0] EXC_TIMEOUT  = 2'b11;

    function automatic logic f3_illegal(input logic is_load, input logic [2:0] f3);
        if (is_load)
            return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        return f3[2] || (f3[1:0] == 2'b11);
    endfunction

    // Only meaningful once funct3 is known to be legal; bit 2 is the unsigned flag.
    function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/rv32i_load_align.sv
// Combinational lane select and sign/zero extension of load read data.
// Zero latency; no flow control.
module rv32i_load_align
    import rv32i_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {24'd0, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/rv32i_lsu_ctrl.sv
// Memory-stage load/store sequencer: one req/ack access on the data port, with stall upstream.
// Load result 2 cycles after accept at best; store frees the pipe 1 cycle after ack; timeout aborts.
module rv32i_lsu_ctrl
    import rv32i_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TMR_W          = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_is_load,
    input  logic [2:0]  mem_funct3,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [4:0]  mem_wb_reg,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic [4:0]  load_reg,
    output logic        exc_valid,
    output logic [1:0]  exc_cause
);

    lsu_state_e  state_q, state_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  wb_q, wb_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic [4:0]  ld_reg_q, ld_reg_d;
    logic        exc_q, exc_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] aligned;

    rv32i_load_align u_align (
        .rdata   (dmem_rdata),
        .funct3  (f3_q),
        .addr_lo (off_q),
        .data    (aligned)
    );

    always_comb begin
        state_d   = state_q;
        f3_d      = f3_q;
        off_d     = off_q;
        wb_d      = wb_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        tmr_d     = tmr_q;
        ld_data_d = ld_data_q;
        ld_reg_d  = ld_reg_q;
        exc_d     = 1'b0;
        cause_d   = cause_q;

        case (state_q)
            ST_IDLE: begin
                if (mem_valid) begin
                    if (f3_illegal(mem_is_load, mem_funct3)) begin
                        exc_d   = 1'b1;
                        cause_d = EXC_ILLEGAL;
                    end else if (addr_misaligned(mem_funct3, mem_addr[1:0])) begin
                        exc_d   = 1'b1;
                        cause_d = EXC_MISALIGN;
                    end else begin
                        f3_d    = mem_funct3;
                        off_d   = mem_addr[1:0];
                        wb_d    = mem_wb_reg;
                        we_d    = !mem_is_load;
                        addr_d  = {mem_addr[31:2], 2'b00};
                        tmr_d   = '0;
                        state_d = ST_BUSY;
                        be_d    = 4'b1111;
                        wdata_d = mem_wdata;
                        if (!mem_is_load) begin
                            case (mem_funct3)
                                F3_SB: begin
                                    be_d    = 4'b0001 << mem_addr[1:0];
                                    wdata_d = {4{mem_wdata[7:0]}};
                                end
                                F3_SH: begin
                                    be_d    = mem_addr[1] ? 4'b1100 : 4'b0011;
                                    wdata_d = {2{mem_wdata[15:0]}};
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            end
            ST_BUSY: begin
                // Ack is tested first so an ack on the final timer cycle still completes.
                if (dmem_ack) begin
                    if (!we_q) begin
                        ld_data_d = aligned;
                        ld_reg_d  = wb_q;
                        state_d   = ST_RESP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    exc_d   = 1'b1;
                    cause_d = EXC_TIMEOUT;
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            f3_q      <= '0;
            off_q     <= '0;
            wb_q      <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            tmr_q     <= '0;
            ld_data_q <= '0;
            ld_reg_q  <= '0;
            exc_q     <= 1'b0;
            cause_q   <= '0;
        end else begin
            state_q   <= state_d;
            f3_q      <= f3_d;
            off_q     <= off_d;
            wb_q      <= wb_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            tmr_q     <= tmr_d;
            ld_data_q <= ld_data_d;
            ld_reg_q  <= ld_reg_d;
            exc_q     <= exc_d;
            cause_q   <= cause_d;
        end
    end

    // Any memory op presented in IDLE holds upstream for that cycle, faulting or not.
    assign stall      = (state_q == ST_BUSY) || ((state_q == ST_IDLE) && mem_valid);
    assign dmem_req   = (state_q == ST_BUSY);
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;
    assign load_valid = (state_q == ST_RESP);
    assign load_data  = ld_data_q;
    assign load_reg   = ld_reg_q;
    assign exc_valid  = exc_q;
    assign exc_cause  = cause_q;

endmodule

// File: tb/tb_rv32i_lsu_ctrl.sv
// Self-checking bench for rv32i_lsu_ctrl: directed scenarios plus randomized accesses
// compared against an arithmetic reference model of the load/store rules.
module tb_rv32i_lsu_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid, mem_is_load;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr, mem_wdata;
    logic [4:0]  mem_wb_reg;
    logic        stall, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        load_valid, exc_valid;
    logic [31:0] load_data;
    logic [4:0]  load_reg;
    logic [1:0]  exc_cause;

    int checks = 0;
    int errors = 0;

    int          ob_req_cnt, ob_stall_cnt, ob_lv_cnt, ob_lv_k, ob_exc_cnt, ob_exc_k;
    logic        ob_stall_acc, ob_both, ob_we;
    logic [1:0]  ob_cause;
    logic [31:0] ob_ldata, ob_addr, ob_wdata;
    logic [4:0]  ob_lreg;
    logic [3:0]  ob_be;

    rv32i_lsu_ctrl #(.TIMEOUT_CYCLES(TO), .TMR_W(5)) dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_is_load(mem_is_load), .mem_funct3(mem_funct3),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wb_reg(mem_wb_reg),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .load_valid(load_valid), .load_data(load_data),
        .load_reg(load_reg), .exc_valid(exc_valid), .exc_cause(exc_cause)
    );

    always #5 clk = ~clk;

    // Reference model: 0 = legal, 1 = misaligned, 2 = illegal funct3
    function automatic int exp_kind(input logic ld, input logic [2:0] f3, input logic [31:0] addr);
        int  size;
        bit  legal;
        if (ld) legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
        else    legal = (f3 <= 2);
        if (!legal) return 2;
        size = 1 << f3[1:0];
        if ((addr % size) != 0) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        longint v;
        int     off;
        off = addr % 4;
        if (f3[1:0] == 2'b00) begin
            v = (rdata >> (8 * off)) & 'hFF;
            if (!f3[2] && v >= 128) v = v - 256;
        end else if (f3[1:0] == 2'b01) begin
            v = (rdata >> (8 * off)) & 'hFFFF;
            if (!f3[2] && v >= 32768) v = v - 65536;
        end else begin
            v = rdata;
        end
        return v[31:0];
    endfunction

    function automatic logic [3:0] exp_be(input logic ld, input logic [2:0] f3, input logic [31:0] addr);
        int off;
        off = addr % 4;
        if (ld || f3 == 2) return 4'hF;
        if (f3 == 0) return 4'(1 << off);
        return (off >= 2) ? 4'hC : 4'h3;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (f3 == 0) return (wd % 256) * 32'h0101_0101;
        if (f3 == 1) return (wd % 65536) * 32'h0001_0001;
        return wd;
    endfunction

    // Presents one op, then plays memory for `window` cycles; k=0 is the first cycle after accept.
    task automatic run_access(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [4:0] wb,
                              input int ack_k, input logic [31:0] rdata, input int window);
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_is_load = ld; mem_funct3 = f3;
        mem_addr = addr; mem_wdata = wdata; mem_wb_reg = wb; dmem_ack = 1'b0;
        @(negedge clk);
        ob_stall_acc = stall;
        ob_req_cnt = 0; ob_stall_cnt = 0; ob_lv_cnt = 0; ob_lv_k = -1;
        ob_exc_cnt = 0; ob_exc_k = -1; ob_both = 1'b0;
        @(posedge clk); #1;
        mem_valid = 1'b0;
        for (int k = 0; k < window; k++) begin
            dmem_ack   = (k == ack_k);
            dmem_rdata = (k == ack_k) ? rdata : $urandom;
            @(negedge clk);
            if (dmem_req) begin
                if (ob_req_cnt == 0) begin
                    ob_addr = dmem_addr; ob_be = dmem_be; ob_we = dmem_we; ob_wdata = dmem_wdata;
                end
                ob_req_cnt++;
            end
            if (stall) ob_stall_cnt++;
            if (load_valid) begin ob_lv_cnt++; ob_lv_k = k; ob_ldata = load_data; ob_lreg = load_reg; end
            if (exc_valid) begin ob_exc_cnt++; ob_exc_k = k; ob_cause = exc_cause; end
            if (load_valid && exc_valid) ob_both = 1'b1;
            @(posedge clk); #1;
        end
        dmem_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; mem_valid = 1'b0; mem_is_load = 1'b0; mem_funct3 = '0;
        mem_addr = '0; mem_wdata = '0; mem_wb_reg = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        #2;
        checks++; if ({stall, dmem_req, dmem_we, load_valid, exc_valid} !== 5'b0) begin errors++; $display("FAIL reset_ctrl got %b exp 00000", {stall, dmem_req, dmem_we, load_valid, exc_valid}); end
        checks++; if (dmem_be !== 4'h0) begin errors++; $display("FAIL reset_be got %h exp 0", dmem_be); end
        checks++; if ({dmem_addr, dmem_wdata} !== 64'h0) begin errors++; $display("FAIL reset_bus got %h exp 0", {dmem_addr, dmem_wdata}); end
        checks++; if ({load_data, load_reg, exc_cause} !== 39'h0) begin errors++; $display("FAIL reset_resp got %h exp 0", {load_data, load_reg, exc_cause}); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_lw();
        run_access(1'b1, 3'b010, 32'h100, 32'h0, 5'd7, 3, 32'hDEAD_BEEF, 7);
        checks++; if (ob_addr !== 32'h100) begin errors++; $display("FAIL lw_addr got %h exp 00000100", ob_addr); end
        checks++; if ({ob_we, ob_be} !== 5'b0_1111) begin errors++; $display("FAIL lw_we_be got %b exp 01111", {ob_we, ob_be}); end
        checks++; if (ob_req_cnt !== 4) begin errors++; $display("FAIL lw_req_cycles got %0d exp 4", ob_req_cnt); end
        checks++; if ({ob_stall_acc, 32'(ob_stall_cnt)} !== {1'b1, 32'd4}) begin errors++; $display("FAIL lw_stall got acc=%b cnt=%0d exp acc=1 cnt=4", ob_stall_acc, ob_stall_cnt); end
        checks++; if (ob_lv_cnt !== 1 || ob_lv_k !== 4) begin errors++; $display("FAIL lw_load_valid got cnt=%0d k=%0d exp cnt=1 k=4", ob_lv_cnt, ob_lv_k); end
        checks++; if ({ob_ldata, ob_lreg} !== {32'hDEAD_BEEF, 5'd7}) begin errors++; $display("FAIL lw_data got %h/%0d exp deadbeef/7", ob_ldata, ob_lreg); end
        checks++; if (load_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_hold got %h exp deadbeef", load_data); end
    endtask

    task automatic test_lb_lbu();
        run_access(1'b1, 3'b000, 32'h103, 32'h0, 5'd9, 1, 32'h80FF_0000, 5);
        checks++; if (ob_ldata !== 32'hFFFF_FF80 || ob_lv_cnt !== 1) begin errors++; $display("FAIL lb_sign got %h cnt=%0d exp ffffff80 cnt=1", ob_ldata, ob_lv_cnt); end
        run_access(1'b1, 3'b100, 32'h103, 32'h0, 5'd9, 1, 32'h80FF_0000, 5);
        checks++; if (ob_ldata !== 32'h0000_0080 || ob_lv_cnt !== 1) begin errors++; $display("FAIL lbu_zero got %h cnt=%0d exp 00000080 cnt=1", ob_ldata, ob_lv_cnt); end
    endtask

    task automatic test_sh();
        run_access(1'b0, 3'b001, 32'h202, 32'h1234_ABCD, 5'd3, 0, 32'h0, 4);
        checks++; if ({ob_we, ob_be} !== 5'b1_1100) begin errors++; $display("FAIL sh_we_be got %b exp 11100", {ob_we, ob_be}); end
        checks++; if (ob_wdata !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_wdata got %h exp abcdabcd", ob_wdata); end
        checks++; if (ob_addr !== 32'h200) begin errors++; $display("FAIL sh_addr got %h exp 00000200", ob_addr); end
        checks++; if (ob_lv_cnt !== 0 || ob_stall_cnt !== 1 || ob_req_cnt !== 1) begin errors++; $display("FAIL sh_flow got lv=%0d stall=%0d req=%0d exp 0/1/1", ob_lv_cnt, ob_stall_cnt, ob_req_cnt); end
        checks++; if (load_data !== 32'h0000_0080) begin errors++; $display("FAIL sh_load_hold got %h exp 00000080", load_data); end
    endtask

    task automatic test_exceptions();
        logic        ld_t [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3_t [4] = '{3'b010, 3'b011, 3'b100, 3'b001};
        logic [31:0] ad_t [4] = '{32'h101, 32'h100, 32'h100, 32'h101};
        logic [1:0]  ca_t [4] = '{2'b01, 2'b10, 2'b10, 2'b01};
        for (int i = 0; i < 4; i++) begin
            run_access(ld_t[i], f3_t[i], ad_t[i], 32'h0, 5'd1, -1, 32'h0, 3);
            checks++; if (ob_exc_cnt !== 1 || ob_exc_k !== 0 || ob_cause !== ca_t[i]) begin errors++; $display("FAIL exc_%0d got cnt=%0d k=%0d cause=%b exp 1/0/%b", i, ob_exc_cnt, ob_exc_k, ob_cause, ca_t[i]); end
            checks++; if (ob_req_cnt !== 0 || ob_stall_cnt !== 0 || ob_stall_acc !== 1'b1 || ob_lv_cnt !== 0) begin errors++; $display("FAIL exc_side_%0d got req=%0d stall=%0d acc=%b lv=%0d exp 0/0/1/0", i, ob_req_cnt, ob_stall_cnt, ob_stall_acc, ob_lv_cnt); end
        end
    endtask

    task automatic test_timeout();
        run_access(1'b1, 3'b010, 32'h300, 32'h0, 5'd4, -1, 32'h0, TO + 4);
        checks++; if (ob_req_cnt !== TO || ob_stall_cnt !== TO) begin errors++; $display("FAIL timeout_req got req=%0d stall=%0d exp %0d", ob_req_cnt, ob_stall_cnt, TO); end
        checks++; if (ob_exc_cnt !== 1 || ob_exc_k !== TO || ob_cause !== 2'b11 || ob_lv_cnt !== 0) begin errors++; $display("FAIL timeout_exc got cnt=%0d k=%0d cause=%b lv=%0d exp 1/%0d/11/0", ob_exc_cnt, ob_exc_k, ob_cause, ob_lv_cnt, TO); end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] rd;
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_is_load = 1'b1; mem_funct3 = 3'b010; mem_addr = 32'h400;
        @(posedge clk); #1;
        mem_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL midrst_pre got req=%b exp 1", dmem_req); end
        #2 reset = 1'b0;
        #1;
        checks++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL midrst_async got req=%b stall=%b exp 0/0", dmem_req, stall); end
        @(posedge clk); #1 reset = 1'b1;
        rd = $urandom;
        run_access(1'b1, 3'b010, 32'h404, 32'h0, 5'd12, 2, rd, 6);
        checks++; if (ob_lv_cnt !== 1 || ob_lv_k !== 3 || ob_ldata !== rd || ob_lreg !== 5'd12) begin errors++; $display("FAIL midrst_after got lv=%0d k=%0d data=%h reg=%0d exp 1/3/%h/12", ob_lv_cnt, ob_lv_k, ob_ldata, ob_lreg, rd); end
    endtask

    task automatic test_random();
        logic        ld;
        logic [2:0]  f3;
        logic [31:0] addr, wd, rd;
        logic [4:0]  wb;
        int          ack_k, kind;
        for (int i = 0; i < 80; i++) begin
            ld = 1'($urandom); f3 = 3'($urandom); addr = $urandom; wd = $urandom;
            rd = $urandom; wb = 5'($urandom); ack_k = $urandom_range(0, 4);
            kind = exp_kind(ld, f3, addr);
            run_access(ld, f3, addr, wd, wb, ack_k, rd, (kind != 0) ? 3 : ack_k + 4);
            checks++; if (ob_both !== 1'b0) begin errors++; $display("FAIL rnd_overlap_%0d got both=1 exp 0", i); end
            if (kind != 0) begin
                checks++; if (ob_exc_cnt !== 1 || ob_cause !== 2'(kind) || ob_req_cnt !== 0) begin errors++; $display("FAIL rnd_exc_%0d got cnt=%0d cause=%b req=%0d exp 1/%0d/0", i, ob_exc_cnt, ob_cause, ob_req_cnt, kind); end
            end else begin
                checks++; if (ob_req_cnt !== ack_k + 1 || ob_exc_cnt !== 0) begin errors++; $display("FAIL rnd_req_%0d got req=%0d exc=%0d exp %0d/0", i, ob_req_cnt, ob_exc_cnt, ack_k + 1); end
                checks++; if (ob_addr !== {addr[31:2], 2'b00} || ob_we !== !ld || ob_be !== exp_be(ld, f3, addr)) begin errors++; $display("FAIL rnd_bus_%0d got %h/%b/%b exp %h/%b/%b", i, ob_addr, ob_we, ob_be, {addr[31:2], 2'b00}, !ld, exp_be(ld, f3, addr)); end
                if (ld) begin
                    checks++; if (ob_lv_cnt !== 1 || ob_lv_k !== ack_k + 1 || ob_ldata !== exp_load(f3, addr, rd) || ob_lreg !== wb) begin errors++; $display("FAIL rnd_load_%0d got lv=%0d k=%0d data=%h reg=%0d exp 1/%0d/%h/%0d", i, ob_lv_cnt, ob_lv_k, ob_ldata, ob_lreg, ack_k + 1, exp_load(f3, addr, rd), wb); end
                end else begin
                    checks++; if (ob_lv_cnt !== 0 || ob_wdata !== exp_wdata(f3, wd) || ob_stall_cnt !== ack_k + 1) begin errors++; $display("FAIL rnd_store_%0d got lv=%0d wdata=%h stall=%0d exp 0/%h/%0d", i, ob_lv_cnt, ob_wdata, ob_stall_cnt, exp_wdata(f3, wd), ack_k + 1); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh();
        test_exceptions();
        test_timeout();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32i_lsu_ctrl.md
Name: rv32i_lsu_ctrl

Overview:
Load/store sequencer for the rv32i pipeline memory stage. It accepts one load or store from exTop. It runs a req/ack transaction on a single-port, variable-latency data memory. It stalls the pipeline while the access is outstanding. It returns aligned, sign/zero-extended load data plus the writeback register, which feed memTop/wbTop and data forwarding.

Parameters:
TIMEOUT_CYCLES, 16, max cycles dmem_req is held without dmem_ack before abort
TMR_W, 5, width of timeout counter (must hold TIMEOUT_CYCLES)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (asserted at 0)
mem_valid  input  1  ex stage presents a memory instruction this cycle
mem_is_load  input  1  1=load, 0=store (qualified by mem_valid)
mem_funct3  input  3  RV32I width/sign code
mem_addr  input  32  effective address from ALU
mem_wdata  input  32  store data (rs2)
mem_wb_reg  input  5  load destination register
stall  output  1  hold upstream pipeline stages
dmem_req  output  1  memory request
dmem_we  output  1  1=write
dmem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
dmem_be  output  4  byte enables
dmem_wdata  output  32  lane-replicated store data
dmem_ack  input  1  memory completes request (same cycle as req allowed)
dmem_rdata  input  32  read data, valid with dmem_ack
load_valid  output  1  one-cycle pulse: load_data/load_reg valid
load_data  output  32  extended load result
load_reg  output  5  destination register
exc_valid  output  1  one-cycle exception pulse
exc_cause  output  2  01 misaligned, 10 illegal funct3, 11 bus timeout

Behaviour:
- Reset (async, reset=0): state IDLE; stall, dmem_req, dmem_we, dmem_be, load_valid, exc_valid = 0; dmem_addr, dmem_wdata, load_data, load_reg, exc_cause, timer = 0. A reset mid-transaction drops dmem_req immediately. No response is produced for the aborted access.
- States: IDLE, BUSY, RESP.
- IDLE, mem_valid=1:
  - Illegal funct3 (load: 011,110,111; store: anything other than 000/001/010): exc_valid=1, cause 10 next cycle; stay IDLE; no bus access.
  - Misaligned (half with addr[0]=1; word with addr[1:0]!=0): exc_valid=1, cause 01 next cycle; stay IDLE; no bus access.
  - Otherwise: latch funct3, addr[1:0], wb_reg and type. Drive the bus registers. Go to BUSY. stall=1 combinationally in this accept cycle.
- Store encoding: SB: be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}. SH: be=addr[1]?1100:0011, wdata={2{wdata[15:0]}}. SW: be=1111, wdata unchanged. Loads use we=0 and be=1111.
- BUSY:
  - dmem_req=1; addr/we/be/wdata stay stable until ack; stall=1; timer increments each cycle.
  - dmem_ack=1: drop req next cycle. A load captures the extracted result and goes to RESP. A store goes straight to IDLE.
  - Timer reaches TIMEOUT_CYCLES-1 without ack: drop req; exc_valid=1, cause 11; go to IDLE.
  - Ack on the same cycle as timeout: the ack wins.
- RESP: load_valid=1 for exactly one cycle; stall=0; return to IDLE. load_data/load_reg hold their values until the next load.
- Latency: ack in the first BUSY cycle gives load_valid 2 cycles after accept. A store frees the pipeline 1 cycle after ack.
- Extraction: LB/LBU select byte addr[1:0]; LH/LHU select half addr[1]; sign-extend for 000/001, zero-extend for 100/101; LW passes through.
- mem_valid while BUSY/RESP is ignored; upstream is frozen by stall.
- A load with mem_wb_reg=0 still performs the access and pulses load_valid.
- exc_valid and load_valid never assert in the same cycle.

Decomposition:
- Package rv32i_lsu_pkg: state enum, funct3 constants (LB/LH/LW/LBU/LHU/SB/SH/SW), exc_cause codes.
- Sub-module rv32i_load_align: combinational extract and sign/zero-extend from (rdata, funct3, addr[1:0]).

Test Plan:
- LW addr 0x100, ack after 3 cycles, rdata 0xDEADBEEF -> dmem_addr 0x100, be 1111; stall high from accept to ack; load_valid with 0xDEADBEEF.
- LB addr 0x103, rdata 0x80FF_0000 (byte3=0x80) -> load_data 0xFFFFFF80. Same access with LBU -> 0x00000080.
- SH addr 0x202, wdata 0x1234ABCD, ack same cycle as req -> be 1100, dmem_wdata 0xABCDABCD, we=1, no load_valid.
- LW addr 0x101 -> exc_valid with cause 01 one cycle later, dmem_req never rises, stall only in that cycle. Funct3 011 -> cause 10.
- No ack with TIMEOUT_CYCLES=16 -> req high 16 cycles, then dropped; exc cause 11; state returns to IDLE.
- reset to 0 during BUSY -> dmem_req and stall drop asynchronously; after release, a new LW completes normally.
